// File: rtl/sdr_pkg.sv
// Shared SDR datapath helpers: CIC internal-width calculation and sign extension,
// used by the CIC interpolator, the modulator and the NCO stages.
package sdr_pkg;

    localparam int SDR_WIDE_W = 128;

    typedef logic signed [SDR_WIDE_W-1:0] sdr_wide_t;

    function automatic int cic_iw(input int width, input int stages, input int rate_log2);
        return width + stages * rate_log2;
    endfunction

    // Sign-extend the low 'width' bits of v to the full wide type.
    function automatic sdr_wide_t sdr_sext(input sdr_wide_t v, input int width);
        sdr_wide_t t;
        t = v <<< (SDR_WIDE_W - width);
        return t >>> (SDR_WIDE_W - width);
    endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One CIC integrator: registered wrap-around accumulator, updates every clk.
module cic_integrator_stage #(
    parameter int IW = 34
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [IW-1:0] i_data,
    output logic signed [IW-1:0] o_acc
);

    logic signed [IW-1:0] r_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
        end else begin
            r_acc <= r_acc + i_data;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator (N combs, zero-stuff by R, N integrators) feeding the delta-sigma modulator.
// Build option: define CIC_INTERP_ROUND_EN for round-half-up with positive saturation at the output.
module cic_interpolator
    import sdr_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int STAGES    = 3,
    parameter int RATE_LOG2 = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             underrun
);

    localparam int IW    = cic_iw(WIDTH, STAGES, RATE_LOG2);
    localparam int SHIFT = (STAGES - 1) * RATE_LOG2;
`ifdef CIC_INTERP_ROUND_EN
    localparam int RB = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
`endif

    logic [RATE_LOG2-1:0]    r_phase;
    logic                    r_buf_full;
    logic [WIDTH-1:0]        r_buf;
    logic                    r_underrun;
    logic                    r_strobe_d;
    logic signed [IW-1:0]    r_dly [STAGES];
    logic signed [IW-1:0]    r_comb_q;
    logic signed [WIDTH-1:0] r_out;

    logic                    w_strobe;
    logic                    w_hs;
    logic signed [IW-1:0]    w_x;
    logic signed [IW-1:0]    w_t;
    logic signed [IW-1:0]    w_d [STAGES];
    logic signed [IW-1:0]    w_comb;
    logic signed [IW-1:0]    w_acc [STAGES+1];

    function automatic logic signed [WIDTH-1:0] f_out_slice(input logic signed [IW-1:0] acc);
        logic signed [WIDTH-1:0] trunc;
        trunc = acc[WIDTH+SHIFT-1 -: WIDTH];
`ifdef CIC_INTERP_ROUND_EN
        if (SHIFT > 0 && acc[RB]) begin
            if (trunc == MAX_POS) begin
                trunc = MAX_POS;
            end else begin
                trunc = trunc + 1'b1;
            end
        end
`endif
        return trunc;
    endfunction

    assign w_strobe = &r_phase;
    assign w_hs     = in_valid & ~r_buf_full;
    assign in_ready = ~r_buf_full;

    // Low-rate side: pick the sample for this strobe (buffer, bypass, or hold) and run the combs.
    always_comb begin
        if (r_buf_full) begin
            w_x = IW'(sdr_sext(sdr_wide_t'(r_buf), WIDTH));
        end else if (in_valid) begin
            w_x = IW'(sdr_sext(sdr_wide_t'(in_data), WIDTH));
        end else begin
            w_x = r_dly[0];
        end
        w_t = w_x;
        for (int k = 0; k < STAGES; k++) begin
            w_d[k] = w_t;
            w_t    = w_t - r_dly[k];
        end
        w_comb = w_t;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase    <= '0;
            r_buf_full <= 1'b0;
            r_buf      <= '0;
            r_underrun <= 1'b0;
            r_strobe_d <= 1'b0;
            r_comb_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_dly[k] <= '0;
            end
        end else begin
            r_phase    <= r_phase + 1'b1;
            r_strobe_d <= w_strobe;
            if (w_strobe) begin
                r_buf_full <= 1'b0;
                if (!r_buf_full && !in_valid) begin
                    r_underrun <= 1'b1;
                end
                r_comb_q <= w_comb;
                for (int k = 0; k < STAGES; k++) begin
                    r_dly[k] <= w_d[k];
                end
            end else if (w_hs) begin
                r_buf      <= in_data;
                r_buf_full <= 1'b1;
            end
        end
    end

    // High-rate side: zero-stuffed comb output into the integrator chain.
    assign w_acc[0] = r_strobe_d ? r_comb_q : '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_integ
        cic_integrator_stage #(.IW(IW)) u_integ (
            .clk    (clk),
            .rst    (rst),
            .i_data (w_acc[k]),
            .o_acc  (w_acc[k+1])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out <= '0;
        end else begin
            r_out <= f_out_slice(w_acc[STAGES]);
        end
    end

    assign out_data = r_out;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator: default build (N=3) plus an N=1 instance, checked against
// a convolution model (upsample by R, filter with boxcar^N, divide by R^(N-1)).
module tb_cic_interpolator;

    localparam int W   = 16;
    localparam int NB  = 2;
    localparam int RL2 = 6;
    localparam int R   = 1 << RL2;
    localparam int NST [NB] = '{3, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0] in_data  [NB];
    logic         in_valid [NB];
    logic         in_ready [NB];
    logic [W-1:0] out_data [NB];
    logic         underrun [NB];

    cic_interpolator #(.WIDTH(W), .STAGES(3), .RATE_LOG2(RL2)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data[0]),
        .in_valid (in_valid[0]),
        .in_ready (in_ready[0]),
        .out_data (out_data[0]),
        .underrun (underrun[0])
    );

    cic_interpolator #(.WIDTH(W), .STAGES(1), .RATE_LOG2(RL2)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data[1]),
        .in_valid (in_valid[1]),
        .in_ready (in_ready[1]),
        .out_data (out_data[1]),
        .underrun (underrun[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int d, input logic signed [63:0] act,
                         input logic signed [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s[dut%0d] t=%0t: got %0d, expected %0d", name, d, $time, act, expv);
        end
    endtask

    // Model state
    longint h    [NB][0:1023];
    int     hl   [NB];
    int     ph   [NB];
    bit     full [NB];
    int     mbuf [NB];
    int     last [NB];
    bit     und  [NB];
    int     ns   [NB];
    int     kcnt [NB];
    int     xs   [NB][0:4095];
    int     exp_out [NB];
    bit     exp_rdy [NB];
    bit     exp_und [NB];

    function automatic int scale(input longint y, input int sh);
        longint q;
        q = y >>> sh;
`ifdef CIC_INTERP_ROUND_EN
        if (sh > 0) begin
            q = (y + (longint'(1) <<< (sh - 1))) >>> sh;
            if (q > (longint'(1) <<< (W - 1)) - 1) q = (longint'(1) <<< (W - 1)) - 1;
        end
`endif
        q = (q <<< (64 - W)) >>> (64 - W);
        return int'(q);
    endfunction

    task automatic model_reset(input int d);
        ph[d] = 0; full[d] = 1'b0; mbuf[d] = 0; last[d] = 0; und[d] = 1'b0;
        ns[d] = 0; kcnt[d] = 0;
        exp_out[d] = 0; exp_rdy[d] = 1'b1; exp_und[d] = 1'b0;
    endtask

    task automatic model_step(input int d);
        int     x;
        bit     strobe, hs;
        longint y;
        int     p, j;
        strobe = (ph[d] == R - 1);
        hs     = in_valid[d] && !full[d];
        x      = 0;
        if (strobe) begin
            if (full[d]) x = mbuf[d];
            else if (hs) x = int'($signed(in_data[d]));
            else begin
                x = last[d];
                und[d] = 1'b1;
            end
            full[d] = 1'b0;
            last[d] = x;
            if (ns[d] < 4096) begin
                xs[d][ns[d]] = x;
                ns[d]++;
            end
        end else if (hs) begin
            mbuf[d] = int'($signed(in_data[d]));
            full[d] = 1'b1;
        end
        p = kcnt[d];
        kcnt[d]++;
        ph[d] = (ph[d] + 1) % R;
        y = 0;
        for (int s = ns[d] - 1; s >= 0; s--) begin
            j = p - (s * R + R - 1) - NST[d] - 1;
            if (j >= hl[d]) break;
            if (j >= 0) y += h[d][j] * longint'(xs[d][s]);
        end
        exp_out[d] = scale(y, (NST[d] - 1) * RL2);
        exp_rdy[d] = !full[d];
        exp_und[d] = und[d];
    endtask

    always @(posedge clk or negedge rst) begin
        for (int d = 0; d < NB; d++) begin
            if (!rst) model_reset(d);
            else model_step(d);
        end
    end

    // Compare process: every cycle, both DUTs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < NB; d++) begin
                check("out_data", d, $signed(out_data[d]), exp_out[d]);
                check("in_ready", d, in_ready[d], exp_rdy[d]);
                check("underrun", d, underrun[d], exp_und[d]);
            end
        end
    end

    bit hs;
    int seq, n_xfer, peak, cnt64, first64, last64, other;

    initial begin
        for (int d = 0; d < NB; d++) begin
            longint t [0:1023];
            for (int i = 0; i < 1024; i++) h[d][i] = 0;
            h[d][0] = 1;
            hl[d]   = 1;
            for (int st = 0; st < NST[d]; st++) begin
                for (int i = 0; i < 1024; i++) t[i] = 0;
                for (int i = 0; i < hl[d]; i++)
                    for (int r = 0; r < R; r++) t[i + r] += h[d][i];
                hl[d] += R - 1;
                for (int i = 0; i < 1024; i++) h[d][i] = t[i];
            end
        end

        in_valid[0] = 1'b1; in_data[0] = 16'd1000;
        in_valid[1] = 1'b1; in_data[1] = 16'd64;
        #2 rst = 1'b0;
        #1 chk_en = 1'b1;

        // Reset held with valid asserted
        repeat (10) begin
            @(negedge clk);
            check("rst_ready", 0, in_ready[0], 1);
            check("rst_out", 0, $signed(out_data[0]), 0);
            check("rst_underrun", 0, underrun[0], 0);
            check("rst_out", 1, $signed(out_data[1]), 0);
        end
        @(posedge clk); #1 rst = 1'b1;

        fork
            begin
                peak = -32768;
                repeat (300) begin
                    @(negedge clk);
                    if (int'($signed(out_data[0])) > peak) peak = int'($signed(out_data[0]));
                end
                check("dc_settle", 0, $signed(out_data[0]), 1000);
                check("dc_peak", 0, peak, 1000);
                check("dc_underrun", 0, underrun[0], 0);
            end
            begin
                @(posedge clk); #1 in_data[1] = '0;
                cnt64 = 0; other = 0; first64 = -1; last64 = -1;
                for (int c = 0; c < 400; c++) begin
                    @(negedge clk);
                    if ($signed(out_data[1]) == 64) begin
                        cnt64++;
                        if (first64 < 0) first64 = c;
                        last64 = c;
                    end else if (out_data[1] != 0) begin
                        other++;
                    end
                end
                check("imp_count", 1, cnt64, 64);
                check("imp_span", 1, last64 - first64 + 1, 64);
                check("imp_other", 1, other, 0);
                check("imp_tail", 1, $signed(out_data[1]), 0);
            end
        join

        // Underrun with DC hold
        in_data[0] = 16'd5000;
        repeat (300) @(negedge clk);
        check("pre_underrun", 0, underrun[0], 0);
        @(posedge clk); #1 in_valid[0] = 1'b0;
        repeat (2 * R + 4) @(negedge clk);
        check("underrun_set", 0, underrun[0], 1);
        check("underrun_hold", 0, $signed(out_data[0]), 5000);
        check("underrun_ready", 0, in_ready[0], 1);

        // Mid-run reset pulse
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out", 0, $signed(out_data[0]), 0);
        check("midrst_ready", 0, in_ready[0], 1);
        check("midrst_underrun", 0, underrun[0], 0);
        @(posedge clk); #1 rst = 1'b1;

        // Backpressure: valid always high, fresh value on every transfer
        seq = 0; n_xfer = 0;
        in_valid[0] = 1'b1;
        in_data[0]  = 16'(-600);
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            hs = in_valid[0] && in_ready[0];
            @(posedge clk); #1;
            if (hs) begin
                seq++;
                in_data[0] = 16'(seq * 37 - 600);
                if (c >= 100 && c < 740) n_xfer++;
            end
        end
        check("xfer_rate", 0, n_xfer, 10);
        check("bp_underrun", 0, underrun[0], 0);

        // Full-scale inputs
        in_data[0] = 16'h7FFF;
        repeat (300) @(negedge clk);
        check("pos_fullscale", 0, $signed(out_data[0]), 32767);
        @(posedge clk); #1 in_data[0] = 16'h8000;
        repeat (300) @(negedge clk);
        check("neg_fullscale", 0, $signed(out_data[0]), -32768);
        check("fs_underrun", 0, underrun[0], 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
